// File: rtl/mem_copy_master.sv
// Memory-to-memory byte copier driving a synchronous single-port memory bus.
// Each byte takes three clocks: read address, latch read data, write.
module mem_copy_master #(
    parameter int RW_LO = 128,
    parameter int RW_HI = 223
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] src_addr,
    input  logic [7:0] dst_addr,
    input  logic [7:0] length,
    output logic [7:0] address,
    output logic [7:0] to_memory,
    output logic       write,
    input  logic [7:0] from_memory,
    output logic       busy,
    output logic       done,
    output logic       error
);

    localparam logic [8:0] RW_LO_C = 9'(RW_LO);
    localparam logic [8:0] RW_HI_C = 9'(RW_HI);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RD    = 2'd1,
        LATCH = 2'd2,
        WR    = 2'd3
    } state_t;

    state_t     state_r, state_s;
    logic [7:0] src_r, src_s;
    logic [7:0] dst_r, dst_s;
    logic [7:0] len_r, len_s;
    logic [7:0] count_r, count_s;
    logic [7:0] address_r, address_s;
    logic [7:0] to_memory_r, to_memory_s;
    logic       write_r, write_s;
    logic       busy_r, busy_s;
    logic       done_r, done_s;
    logic       error_r, error_s;
    logic [8:0] dst_end_s;
    logic [8:0] src_end_s;
    logic       reject_s;

    // Range check on the incoming request; sums are 9 bits so wrap past 255 is caught
    always_comb begin
        dst_end_s = {1'b0, dst_addr} + {1'b0, length} - 9'd1;
        src_end_s = {1'b0, src_addr} + {1'b0, length} - 9'd1;
        reject_s  = (length != 8'd0) &&
                    (({1'b0, dst_addr} < RW_LO_C) || (dst_end_s > RW_HI_C) || (src_end_s > 9'd255));
    end

    // Next-state and next-output logic for the copy sequencer
    always_comb begin
        state_s     = state_r;
        src_s       = src_r;
        dst_s       = dst_r;
        len_s       = len_r;
        count_s     = count_r;
        address_s   = address_r;
        to_memory_s = to_memory_r;
        write_s     = 1'b0;
        busy_s      = busy_r;
        done_s      = 1'b0;
        error_s     = error_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    src_s   = src_addr;
                    dst_s   = dst_addr;
                    len_s   = length;
                    count_s = 8'd0;
                    if (reject_s) begin
                        error_s = 1'b1;
                        done_s  = 1'b1;
                    end else if (length == 8'd0) begin
                        error_s = 1'b0;
                        done_s  = 1'b1;
                    end else begin
                        error_s   = 1'b0;
                        busy_s    = 1'b1;
                        address_s = src_addr;
                        state_s   = RD;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            RD: begin
                state_s = LATCH;
            end
            LATCH: begin
                to_memory_s = from_memory;
                address_s   = dst_r;
                write_s     = 1'b1;
                state_s     = WR;
            end
            WR: begin
                src_s   = src_r + 8'd1;
                dst_s   = dst_r + 8'd1;
                count_s = count_r + 8'd1;
                // count_r is the number copied before this write completes
                if (({1'b0, count_r} + 9'd1) < {1'b0, len_r}) begin
                    address_s = src_r + 8'd1;
                    state_s   = RD;
                end else begin
                    busy_s  = 1'b0;
                    done_s  = 1'b1;
                    state_s = IDLE;
                end
            end
            default: begin
                busy_s  = 1'b0;
                state_s = IDLE;
            end
        endcase
    end

    // State and registered bus outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r     <= IDLE;
            src_r       <= 8'd0;
            dst_r       <= 8'd0;
            len_r       <= 8'd0;
            count_r     <= 8'd0;
            address_r   <= 8'd0;
            to_memory_r <= 8'd0;
            write_r     <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            error_r     <= 1'b0;
        end else begin
            state_r     <= state_s;
            src_r       <= src_s;
            dst_r       <= dst_s;
            len_r       <= len_s;
            count_r     <= count_s;
            address_r   <= address_s;
            to_memory_r <= to_memory_s;
            write_r     <= write_s;
            busy_r      <= busy_s;
            done_r      <= done_s;
            error_r     <= error_s;
        end
    end

    assign address   = address_r;
    assign to_memory = to_memory_r;
    assign write     = write_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign error     = error_r;

endmodule

// File: tb/tb_mem_copy_master.sv
// Directed bench for mem_copy_master with a synchronous-read memory model.
module tb_mem_copy_master;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [7:0] src_addr = 8'd0;
    logic [7:0] dst_addr = 8'd0;
    logic [7:0] length = 8'd0;
    logic [7:0] address;
    logic [7:0] to_memory;
    logic       write;
    logic [7:0] from_memory;
    logic       busy;
    logic       done;
    logic       error;

    logic [7:0] mem [256];
    logic       pl_en = 1'b0;
    logic [7:0] pl_addr = 8'd0;
    logic [7:0] pl_data = 8'd0;

    int busy_cnt = 0;
    int write_cnt = 0;
    int done_cnt = 0;
    int consec_cnt = 0;
    logic wr_prev = 1'b0;

    int n_checks = 0;
    int n_fail = 0;

    mem_copy_master #(.RW_LO(128), .RW_HI(223)) dut (
        .clock(clock), .reset(reset), .start(start),
        .src_addr(src_addr), .dst_addr(dst_addr), .length(length),
        .address(address), .to_memory(to_memory), .write(write),
        .from_memory(from_memory), .busy(busy), .done(done), .error(error)
    );

    always #5 clock = ~clock;

    // Synchronous single-port memory; preload port shares the write path
    always @(posedge clock) begin
        if (pl_en) mem[pl_addr] <= pl_data;
        else if (write) mem[address] <= to_memory;
        from_memory <= mem[address];
    end

    // Activity counters sampled mid-cycle
    always @(negedge clock) begin
        if (busy) busy_cnt <= busy_cnt + 1;
        if (write) write_cnt <= write_cnt + 1;
        if (done) done_cnt <= done_cnt + 1;
        if (write && wr_prev) consec_cnt <= consec_cnt + 1;
        wr_prev <= write;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic poke(input logic [7:0] a, input logic [7:0] d);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        tick();
        pl_en = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(); tick();
        n_checks += 6;
        if (address !== 8'h00) begin n_fail++; $display("FAIL reset_address: got %h want 00", address); end
        if (to_memory !== 8'h00) begin n_fail++; $display("FAIL reset_to_memory: got %h want 00", to_memory); end
        if (write !== 1'b0) begin n_fail++; $display("FAIL reset_write: got %b want 0", write); end
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
        if (error !== 1'b0) begin n_fail++; $display("FAIL reset_error: got %b want 0", error); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_basic_copy();
        int b0, w0, d0, c0, lat;
        poke(8'h10, 8'hAA); poke(8'h11, 8'hBB); poke(8'h12, 8'hCC);
        poke(8'h80, 8'h00); poke(8'h81, 8'h00); poke(8'h82, 8'h00);
        b0 = busy_cnt; w0 = write_cnt; d0 = done_cnt; c0 = consec_cnt;
        start = 1'b1; src_addr = 8'h10; dst_addr = 8'h80; length = 8'd3;
        tick();
        start = 1'b0;
        n_checks += 3;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy_k: got %b want 1", busy); end
        if (address !== 8'h10) begin n_fail++; $display("FAIL basic_addr_k: got %h want 10", address); end
        if (write !== 1'b0) begin n_fail++; $display("FAIL basic_write_k: got %b want 0", write); end
        lat = 0;
        for (int i = 1; i <= 30; i++) begin
            tick();
            if (done === 1'b1) begin lat = i; break; end
        end
        n_checks++;
        if (lat != 9) begin n_fail++; $display("FAIL basic_done_latency: got %0d want 9", lat); end
        tick();
        n_checks += 9;
        if (done !== 1'b0) begin n_fail++; $display("FAIL basic_done_pulse: got %b want 0", done); end
        if (busy_cnt - b0 != 9) begin n_fail++; $display("FAIL basic_busy_cycles: got %0d want 9", busy_cnt - b0); end
        if (write_cnt - w0 != 3) begin n_fail++; $display("FAIL basic_write_cycles: got %0d want 3", write_cnt - w0); end
        if (consec_cnt - c0 != 0) begin n_fail++; $display("FAIL basic_write_single: got %0d want 0", consec_cnt - c0); end
        if (done_cnt - d0 != 1) begin n_fail++; $display("FAIL basic_done_count: got %0d want 1", done_cnt - d0); end
        if (mem[8'h80] !== 8'hAA) begin n_fail++; $display("FAIL basic_m80: got %h want AA", mem[8'h80]); end
        if (mem[8'h81] !== 8'hBB) begin n_fail++; $display("FAIL basic_m81: got %h want BB", mem[8'h81]); end
        if (mem[8'h82] !== 8'hCC) begin n_fail++; $display("FAIL basic_m82: got %h want CC", mem[8'h82]); end
        if (error !== 1'b0) begin n_fail++; $display("FAIL basic_error: got %b want 0", error); end
    endtask

    task automatic test_reject();
        int w0;
        w0 = write_cnt;
        start = 1'b1; src_addr = 8'h90; dst_addr = 8'hDE; length = 8'd3;
        tick();
        start = 1'b0;
        n_checks += 3;
        if (error !== 1'b1) begin n_fail++; $display("FAIL reject_error: got %b want 1", error); end
        if (done !== 1'b1) begin n_fail++; $display("FAIL reject_done: got %b want 1", done); end
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reject_busy: got %b want 0", busy); end
        tick(); tick(); tick();
        n_checks += 3;
        if (error !== 1'b1) begin n_fail++; $display("FAIL reject_error_held: got %b want 1", error); end
        if (done !== 1'b0) begin n_fail++; $display("FAIL reject_done_pulse: got %b want 0", done); end
        if (write_cnt - w0 != 0) begin n_fail++; $display("FAIL reject_no_write: got %0d want 0", write_cnt - w0); end
        // Destination below the writable window
        start = 1'b1; src_addr = 8'h00; dst_addr = 8'h7F; length = 8'd1;
        tick();
        start = 1'b0;
        n_checks += 2;
        if (error !== 1'b1) begin n_fail++; $display("FAIL reject_dst_low: got %b want 1", error); end
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reject_dst_low_busy: got %b want 0", busy); end
        tick();
    endtask

    task automatic test_zero_len();
        int b0, w0;
        b0 = busy_cnt; w0 = write_cnt;
        start = 1'b1; src_addr = 8'hF0; dst_addr = 8'h00; length = 8'd0;
        tick();
        start = 1'b0;
        n_checks += 3;
        if (done !== 1'b1) begin n_fail++; $display("FAIL zero_done: got %b want 1", done); end
        if (error !== 1'b0) begin n_fail++; $display("FAIL zero_error: got %b want 0", error); end
        if (busy !== 1'b0) begin n_fail++; $display("FAIL zero_busy: got %b want 0", busy); end
        tick(); tick();
        n_checks += 3;
        if (done !== 1'b0) begin n_fail++; $display("FAIL zero_done_pulse: got %b want 0", done); end
        if (busy_cnt - b0 != 0) begin n_fail++; $display("FAIL zero_busy_cycles: got %0d want 0", busy_cnt - b0); end
        if (write_cnt - w0 != 0) begin n_fail++; $display("FAIL zero_no_write: got %0d want 0", write_cnt - w0); end
    endtask

    task automatic test_start_held();
        int b0, lat;
        poke(8'h20, 8'h11); poke(8'h21, 8'h22);
        poke(8'h90, 8'h00); poke(8'h91, 8'h00); poke(8'hA0, 8'h00); poke(8'h30, 8'h77);
        b0 = busy_cnt;
        start = 1'b1; src_addr = 8'h20; dst_addr = 8'h90; length = 8'd2;
        tick();
        src_addr = 8'h30; dst_addr = 8'hA0; length = 8'd5;
        lat = 0;
        for (int i = 1; i <= 30; i++) begin
            tick();
            if (done === 1'b1) begin lat = i; break; end
        end
        start = 1'b0;
        tick(); tick();
        n_checks += 5;
        if (lat != 6) begin n_fail++; $display("FAIL held_done_latency: got %0d want 6", lat); end
        if (busy_cnt - b0 != 6) begin n_fail++; $display("FAIL held_busy_cycles: got %0d want 6", busy_cnt - b0); end
        if (mem[8'h90] !== 8'h11) begin n_fail++; $display("FAIL held_m90: got %h want 11", mem[8'h90]); end
        if (mem[8'h91] !== 8'h22) begin n_fail++; $display("FAIL held_m91: got %h want 22", mem[8'h91]); end
        if (mem[8'hA0] !== 8'h00) begin n_fail++; $display("FAIL held_mA0: got %h want 00", mem[8'hA0]); end
    endtask

    task automatic test_back_to_back();
        int lat;
        poke(8'h40, 8'h3C); poke(8'h41, 8'h4D); poke(8'hB0, 8'h00); poke(8'hB1, 8'h00);
        start = 1'b1; src_addr = 8'h40; dst_addr = 8'hB0; length = 8'd1;
        tick();
        start = 1'b0;
        lat = 0;
        for (int i = 1; i <= 30; i++) begin
            tick();
            if (done === 1'b1) begin lat = i; break; end
        end
        start = 1'b1; src_addr = 8'h41; dst_addr = 8'hB1; length = 8'd1;
        tick();
        start = 1'b0;
        n_checks += 4;
        if (lat != 3) begin n_fail++; $display("FAIL b2b_first_latency: got %0d want 3", lat); end
        if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_accept_busy: got %b want 1", busy); end
        if (done !== 1'b0) begin n_fail++; $display("FAIL b2b_done_drop: got %b want 0", done); end
        if (address !== 8'h41) begin n_fail++; $display("FAIL b2b_addr: got %h want 41", address); end
        lat = 0;
        for (int i = 1; i <= 30; i++) begin
            tick();
            if (done === 1'b1) begin lat = i; break; end
        end
        n_checks += 3;
        if (lat != 3) begin n_fail++; $display("FAIL b2b_second_latency: got %0d want 3", lat); end
        if (mem[8'hB0] !== 8'h3C) begin n_fail++; $display("FAIL b2b_mB0: got %h want 3C", mem[8'hB0]); end
        if (mem[8'hB1] !== 8'h4D) begin n_fail++; $display("FAIL b2b_mB1: got %h want 4D", mem[8'hB1]); end
        tick();
    endtask

    task automatic test_reset_abort();
        int w0;
        poke(8'h50, 8'h5A); poke(8'h51, 8'h5B); poke(8'h52, 8'h5C); poke(8'h53, 8'h5D);
        poke(8'hC0, 8'h00); poke(8'hC1, 8'h00); poke(8'hC2, 8'h00);
        w0 = write_cnt;
        start = 1'b1; src_addr = 8'h50; dst_addr = 8'hC0; length = 8'd4;
        tick();
        start = 1'b0;
        tick(); tick(); tick(); tick();
        reset = 1'b1;
        tick();
        n_checks += 3;
        if (write !== 1'b0) begin n_fail++; $display("FAIL abort_write: got %b want 0", write); end
        if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b want 0", busy); end
        if (done !== 1'b0) begin n_fail++; $display("FAIL abort_done: got %b want 0", done); end
        reset = 1'b0;
        tick(); tick(); tick(); tick();
        n_checks += 4;
        if (mem[8'hC0] !== 8'h5A) begin n_fail++; $display("FAIL abort_mC0: got %h want 5A", mem[8'hC0]); end
        if (mem[8'hC1] !== 8'h00) begin n_fail++; $display("FAIL abort_mC1: got %h want 00", mem[8'hC1]); end
        if (write_cnt - w0 != 1) begin n_fail++; $display("FAIL abort_write_count: got %0d want 1", write_cnt - w0); end
        if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_idle: got %b want 0", busy); end
    endtask

    task automatic test_boundary();
        int lat;
        poke(8'h80, 8'h96); poke(8'hDF, 8'h00);
        start = 1'b1; src_addr = 8'h80; dst_addr = 8'hDF; length = 8'd1;
        tick();
        start = 1'b0;
        n_checks += 2;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL bound_accept: got %b want 1", busy); end
        if (error !== 1'b0) begin n_fail++; $display("FAIL bound_error: got %b want 0", error); end
        lat = 0;
        for (int i = 1; i <= 30; i++) begin
            tick();
            if (done === 1'b1) begin lat = i; break; end
        end
        n_checks += 2;
        if (lat != 3) begin n_fail++; $display("FAIL bound_latency: got %0d want 3", lat); end
        if (mem[8'hDF] !== 8'h96) begin n_fail++; $display("FAIL bound_mDF: got %h want 96", mem[8'hDF]); end
        tick();
        // Source range wrapping past 0xFF is rejected
        start = 1'b1; src_addr = 8'hFF; dst_addr = 8'h80; length = 8'd2;
        tick();
        start = 1'b0;
        n_checks += 2;
        if (error !== 1'b1) begin n_fail++; $display("FAIL bound_src_wrap: got %b want 1", error); end
        if (busy !== 1'b0) begin n_fail++; $display("FAIL bound_src_wrap_busy: got %b want 0", busy); end
        tick();
    endtask

    initial begin
        test_reset();
        test_basic_copy();
        test_reject();
        test_zero_len();
        test_start_held();
        test_back_to_back();
        test_reset_abort();
        test_boundary();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
